// File: rtl/frame_serializer_pkg.sv
// rtl/frame_serializer_pkg.sv - shared types and helpers for the frame serializer
package frame_serializer_pkg;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/frame_start_tracker.sv
// rtl/frame_start_tracker.sv - start edge detect delayed to the latch's frame-ready point
module frame_start_tracker #(
    parameter int STAGE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic cap
);

    logic         start_q;
    logic         start_qq;
    logic [STAGE:0] dly;

    // one extra register ahead of the delay line lands cap on the edge after the latch settles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q  <= 1'b0;
            start_qq <= 1'b0;
            dly      <= '0;
        end else begin
            start_q  <= start;
            start_qq <= start_q;
            dly      <= {dly[STAGE-1:0], start_q & ~start_qq};
        end
    end

    assign cap = dly[STAGE];

endmodule

// File: rtl/frame_serializer.sv
// rtl/frame_serializer.sv - captures a parallel frame and replays it on a valid/ready stream
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int STAGE  = 8,
    parameter int DWIDTH = 8,
    parameter int SWIDTH = DWIDTH + $clog2(STAGE),
    parameter int IW     = idx_width(STAGE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] frame_in [0:STAGE-1],
    input  logic              clr_ovf,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [IW-1:0]     out_idx,
    output logic [SWIDTH-1:0] frame_sum,
    output logic              busy,
    output logic              ovf
);

    state_t            state;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_nxt;
    logic [DWIDTH-1:0] frame_buf [0:STAGE-1];
    logic [SWIDTH-1:0] sum_in;
    logic              cap;
    logic              hs;
    logic              at_last;
    logic              ovf_set;

    frame_start_tracker #(.STAGE(STAGE)) u_tracker (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cap   (cap)
    );

    always_comb begin
        sum_in = '0;
        for (int i = 0; i < STAGE; i++) begin
            sum_in = sum_in + SWIDTH'(frame_in[i]);
        end
    end

    assign idx_nxt = idx + IW'(1);
    assign at_last = (idx == IW'(STAGE - 1));
    assign hs      = (state == SEND) && out_ready;
    // only the final handshake frees the buffer for a new frame
    assign ovf_set = cap && (state == SEND) && !(hs && at_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            for (int i = 0; i < STAGE; i++) begin
                frame_buf[i] <= '0;
            end
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            frame_sum <= '0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cap) begin
                        frame_buf <= frame_in;
                        frame_sum <= sum_in;
                        state     <= SEND;
                        idx       <= '0;
                        out_data  <= frame_in[0];
                        out_idx   <= '0;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (!at_last) begin
                            idx      <= idx_nxt;
                            out_data <= frame_buf[idx_nxt];
                            out_idx  <= idx_nxt;
                            out_last <= (idx_nxt == IW'(STAGE - 1));
                        end else if (cap) begin
                            frame_buf <= frame_in;
                            frame_sum <= sum_in;
                            idx       <= '0;
                            out_data  <= frame_in[0];
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            idx       <= '0;
                            out_data  <= '0;
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// tb/tb_frame_serializer.sv - randomized bench against a queue-based frame model
module tb_frame_serializer;

    localparam int STAGE  = 8;
    localparam int DWIDTH = 8;
    localparam int SWIDTH = DWIDTH + $clog2(STAGE);
    localparam int IW     = $clog2(STAGE);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DWIDTH-1:0] frame_in [0:STAGE-1];
    logic              clr_ovf;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [IW-1:0]     out_idx;
    logic [SWIDTH-1:0] frame_sum;
    logic              busy;
    logic              ovf;

    int vectors    = 0;
    int miscompares = 0;
    int dut_hs     = 0;

    int q[$];
    int msum;
    bit movf;
    bit hist[$];

    frame_serializer #(.STAGE(STAGE), .DWIDTH(DWIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_in  (frame_in),
        .clr_ovf   (clr_ovf),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .frame_sum (frame_sum),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        msum = 0;
        movf = 1'b0;
        hist.delete();
        repeat (STAGE + 3) hist.push_back(1'b0);
    endtask

    // hist holds start samples from edges k-STAGE-3 .. k-1; a frame is ready at edge k
    // when start first went high STAGE+2 edges earlier
    task automatic tick();
        bit hs;
        bit cap;
        int s;
        @(negedge clk);
        if (rst) model_reset();
        check("valid", out_valid, q.size() != 0);
        check("busy", busy, q.size() != 0);
        check("sum", frame_sum, msum);
        check("ovf", ovf, movf);
        if (q.size() != 0) begin
            check("data", out_data, q[0]);
            check("idx", out_idx, STAGE - q.size());
            check("last", out_last, q.size() == 1);
        end
        if (out_valid && out_ready) dut_hs++;
        if (!rst) begin
            hs  = (q.size() != 0) && out_ready;
            cap = hist[1] && !hist[0];
            void'(hist.pop_front());
            hist.push_back(start);
            if (hs) void'(q.pop_front());
            if (cap && q.size() == 0) begin
                s = 0;
                for (int i = 0; i < STAGE; i++) begin
                    q.push_back(int'(frame_in[i]));
                    s += int'(frame_in[i]);
                end
                msum = s;
                if (clr_ovf) movf = 1'b0;
            end else if (cap) begin
                movf = 1'b1;
            end else if (clr_ovf) begin
                movf = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < STAGE; i++) frame_in[i] = DWIDTH'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clr_ovf = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < STAGE; i++) frame_in[i] = '0;
        tick();
        tick();
        rst = 1'b0;

        // basic frame 1..8
        out_ready = 1'b1;
        for (int i = 0; i < STAGE; i++) frame_in[i] = DWIDTH'(i + 1);
        dut_hs = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (STAGE + 14) tick();
        check("basic_hs", dut_hs, 8);
        check("basic_sum", frame_sum, 36);

        // backpressure with all-ones frame
        for (int i = 0; i < STAGE; i++) frame_in[i] = '1;
        dut_hs = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            out_ready = (k % 3 == 0);
            tick();
        end
        check("bp_hs", dut_hs, 8);
        check("bp_sum", frame_sum, 2040);

        // back-to-back: second cap lands on the last handshake of the first
        out_ready = 1'b1;
        dut_hs = 0;
        rand_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            rand_frame();
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            rand_frame();
            tick();
        end
        check("b2b_hs", dut_hs, 16);

        // overflow: second cap while idx=2
        dut_hs = 0;
        rand_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (25) tick();
        check("ovf_hs", dut_hs, 8);
        check("ovf_set", ovf, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tick();
        check("ovf_clr", ovf, 0);

        // held start yields one frame
        dut_hs = 0;
        start = 1'b1;
        repeat (20) tick();
        start = 1'b0;
        repeat (20) tick();
        check("held_hs", dut_hs, 8);

        // reset mid-frame at idx 3
        rand_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            bit hit = 1'b0;
            for (int k = 0; k < 40 && !hit; k++) begin
                if (q.size() == STAGE - 3) hit = 1'b1;
                else tick();
            end
            check("idx3_reached", hit, 1);
        end
        rst = 1'b1;
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_sum", frame_sum, 0);
        rst = 1'b0;
        dut_hs = 0;
        repeat (20) tick();
        check("rst_no_words", dut_hs, 0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            start     = ($urandom_range(0, 11) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_ovf   = ($urandom_range(0, 31) == 0);
            rand_frame();
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
